mem_bank_hs: RTL
================

Name: mem_bank_hs

Overview:
- Parametrised successor of the team's 8-bit/256-entry single-clock memory.
- Single-port-per-direction synchronous RAM:
  - one write channel and one read-request channel, each with a valid/ready handshake;
  - one buffered read-response channel with back-pressure;
  - byte-enabled writes;
  - write-first collision bypass;
  - hardware zero-initialisation after reset.
- Sits between bus-side masters (lab CPU/DMA) and storage as a drop-in data/scratch memory.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; need not be a power of two.
- ADDR_WIDTH, 8, address bus width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- INIT_ZERO, 1, 1 = clear all words after reset before accepting traffic; 0 = skip (contents undefined).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request present.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i selects byte [8i+7:8i].
- rd_valid  in  1  read request present.
- rd_ready  out  1  read accepted when rd_valid && rd_ready.
- rd_addr  in  ADDR_WIDTH  read word address.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_err  out  1  response is for an out-of-range address.
- init_done  out  1  high once initialisation is complete.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0. The FSM enters INIT, or RUN if INIT_ZERO=0.
- FSM states INIT and RUN:
  - INIT: a clear counter writes 0 to word k in cycle k for k=0..DEPTH-1, taking DEPTH cycles after reset release. wr_ready=rd_ready=0 throughout.
  - INIT to RUN: happens after word DEPTH-1 is written. init_done rises in the same cycle the FSM enters RUN.
  - RUN: stays in RUN until the next reset.
- Write channel, RUN state:
  - wr_ready is constantly 1.
  - On an accepted write, each byte i with wr_be[i]=1 is updated at the clock edge; bytes with wr_be[i]=0 are untouched.
  - wr_be=0 is a legal no-op.
  - wr_addr >= DEPTH: the write is silently dropped, with no wrap or alias.
- Read channel, RUN state:
  - rd_ready = !rsp_valid || rsp_ready (combinational).
  - An accepted read loads the response register at the next edge. rsp_valid is high one cycle after acceptance (latency 1).
  - Back-to-back reads sustain one per cycle while rsp_ready=1.
- Response channel:
  - rsp_valid/rsp_data/rsp_err hold stable while rsp_valid && !rsp_ready.
  - rsp_valid clears on acceptance unless a new read is accepted in the same cycle.
  - A memory write to the address held in the stalled response does not modify the held rsp_data.
- Out-of-range read (rd_addr >= DEPTH): the request is accepted normally, with rsp_data=0 and rsp_err=1. In-range reads give rsp_err=0.
- Same-cycle write+read to the same in-range address (write-first):
  - rsp_data takes the new bytes where wr_be=1 and the old bytes elsewhere.
  - A write and read to different addresses proceed independently.
- Reset mid-operation:
  - rsp_valid drops immediately (asynchronously).
  - Any pending response is lost, and INIT restarts from word 0.
  - Memory contents are not guaranteed preserved when INIT_ZERO=0.
- Arithmetic:
  - The clear counter is ADDR_WIDTH+1 bits so that DEPTH = 2**ADDR_WIDTH terminates correctly.
  - The range compare is unsigned.

Decomposition:
- Package mem_bank_pkg:
  - state enum {ST_INIT, ST_RUN};
  - function byte_merge(old, new, be);
  - localparam NUM_BYTES = DATA_WIDTH/8.
- Sub-module mem_bank_array:
  - plain storage array with one write port (byte enables) and one registered read port;
  - no handshake logic, so it can be swapped for a vendor RAM macro.
- The top level holds the FSM, handshakes, response register, bypass and range check.

Test Plan:
- Reset release, DEPTH=256, INIT_ZERO=1 -> wr_ready/rd_ready stay 0 for exactly 256 cycles, then init_done=1; a read of addr 0xFF returns 0x00000000 with rsp_err=0.
- Write addr 0x10 data 0xAABBCCDD be=4'b1111, then write 0x11223344 be=4'b0101, then read 0x10 -> rsp_data=0xAA22CC44 one cycle after acceptance.
- Same-cycle write 0x20 data 0x12345678 be=4'b0011 and read 0x20 (old value 0xFFFFFFFF) -> rsp_data=0xFFFF5678; a following read of 0x20 returns the same value.
- DEPTH=200: write addr 0xC8, then read addr 0xC8 -> rsp_data=0, rsp_err=1; a read of addr 0x48 is unaffected.
- Read 0x10 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data stable, rd_ready=0, a second rd_valid is not accepted; rsp_ready=1 -> both responses arrive in order, 1/cycle.
- Assert rst_n low while rsp_valid=1 -> rsp_valid=0 immediately, init_done=0, 256-cycle INIT restarts; no stale response appears afterwards.

Source files
------------

// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the handshaked memory bank.
package mem_bank_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_e;

  // Selects the new byte where its enable is set, otherwise keeps the old one.
  function automatic logic [BYTE_W-1:0] byte_merge(input logic [BYTE_W-1:0] old_b,
                                                   input logic [BYTE_W-1:0] new_b,
                                                   input logic              be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mem_bank_array.sv
// Plain word storage: one byte-enabled write port, one registered read port.
module mem_bank_array
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/BYTE_W-1:0] wbe,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read returns the pre-write contents; the caller handles any bypass.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wbe[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bank_hs.sv
// Handshaked memory bank: init FSM, write/read channels, buffered response with
// write-first collision bypass and out-of-range detection.
module mem_bank_hs
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/BYTE_W-1:0] wr_be,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_err,
  output logic                         init_done
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_C  = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam state_e RESET_ST = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic                  init_we;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q;
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic [NUM_BYTES-1:0]  byp_be_q;

  logic                  wr_in_range, rd_in_range;
  logic                  wr_fire, rd_fire;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [NUM_BYTES-1:0]  arr_wbe;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic [DATA_WIDTH-1:0] merged;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;

  // run_q gates the channels, so nothing is accepted in the cycle reset releases.
  assign wr_ready  = run_q;
  assign rd_ready  = run_q && (!rsp_valid_q || rsp_ready);
  assign init_done = run_q;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    init_we = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end
      end
      ST_RUN: run_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_ST;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    arr_we    = init_we || (wr_fire && wr_in_range);
    arr_waddr = init_we ? cnt_q[ADDR_WIDTH-1:0] : wr_addr;
    arr_wdata = init_we ? '0 : wr_data;
    arr_wbe   = init_we ? '1 : wr_be;
  end

  mem_bank_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wbe   (arr_wbe),
    .re    (rd_fire && rd_in_range),
    .raddr (rd_addr),
    .rdata (arr_rdata)
  );

  always_comb begin
    if (rd_fire)        rsp_valid_d = 1'b1;
    else if (rsp_ready) rsp_valid_d = 1'b0;
    else                rsp_valid_d = rsp_valid_q;
  end

  // Write data captured alongside a colliding read; merged over the array's old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      hit_q       <= 1'b0;
      byp_data_q  <= '0;
      byp_be_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (rd_fire) begin
        rsp_err_q  <= !rd_in_range;
        hit_q      <= wr_fire && wr_in_range && rd_in_range && (wr_addr == rd_addr);
        byp_data_q <= wr_data;
        byp_be_q   <= wr_be;
      end
    end
  end

  always_comb begin
    merged = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      merged[i*BYTE_W +: BYTE_W] = byte_merge(arr_rdata[i*BYTE_W +: BYTE_W],
                                              byp_data_q[i*BYTE_W +: BYTE_W],
                                              hit_q && byp_be_q[i]);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && rsp_err_q;
  assign rsp_data  = (rsp_valid_q && !rsp_err_q) ? merged : '0;

endmodule
